rp_axi_wr_arbiter: RTL

- Round-robin arbiter sharing one PS AXI3 HP write port (DDR path) between NREQ streaming writers (ADC/DMA capture channels).
- Sequences each granted burst: AW, then W beats, then B, and returns per-requester done/error.
- Sits in the PL between the capture engines and the PS7 S_AXI_HP0 slave.

---
 rtl/rp_axi_wr_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rp_axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write port between NREQ burst writers.
// Optional B-response timeout is enabled with `define RP_AXI_WR_ARB_TIMEOUT_EN.
//
// Handshake rule: a transfer happens on a rising clk_i edge where valid and
// ready are both high; valid never waits for ready, and it holds until accepted.
module rp_axi_wr_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 64
`ifdef RP_AXI_WR_ARB_TIMEOUT_EN
  , parameter int TMO = 1024
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*4-1:0]    req_len_i,
  output logic [NREQ-1:0]      gnt_o,
  input  logic [NREQ*DW-1:0]   wdat_i,
  input  logic [NREQ-1:0]      wvld_i,
  output logic [NREQ-1:0]      wrdy_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic [AW-1:0]        m_awaddr_o,
  output logic [3:0]           m_awlen_o,
  output logic [2:0]           m_awsize_o,
  output logic [1:0]           m_awburst_o,
  output logic                 m_awvalid_o,
  input  logic                 m_awready_i,
  output logic [DW-1:0]        m_wdata_o,
  output logic [DW/8-1:0]      m_wstrb_o,
  output logic                 m_wlast_o,
  output logic                 m_wvalid_o,
  input  logic                 m_wready_i,
  input  logic [1:0]           m_bresp_i,
  input  logic                 m_bvalid_i,
  output logic                 m_bready_o,
  output logic [1:0]           dbg_state_o
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(DW/8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [3:0]      awlen_q, awlen_d, cnt_q, cnt_d;
  logic            found;
  logic [IW-1:0]   pick;
  int              idx;
  logic            w_hs;
  logic            tmo_hit;
  logic            unused_bresp;

  // Only SLVERR/DECERR (bit 1) count as errors; EXOKAY is not used on this path.
  assign unused_bresp = m_bresp_i[0];

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign m_awvalid_o = (state_q == ADDR);
  assign m_wvalid_o  = (state_q == DATA) && wvld_i[last_q];
  assign m_wdata_o   = (state_q == DATA) ? wdat_i[last_q*DW +: DW] : '0;
  assign m_wlast_o   = m_wvalid_o && (cnt_q == awlen_q);
  assign wrdy_o      = ((state_q == DATA) && m_wready_i) ? gnt_q : '0;
  assign w_hs        = m_wvalid_o && m_wready_i;
  assign m_wstrb_o   = '1;
  assign m_awsize_o  = 3'(SW);
  assign m_awburst_o = 2'b01;
  assign m_awaddr_o  = awaddr_q;
  assign m_awlen_o   = awlen_q;
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

`ifdef RP_AXI_WR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == RESP && !m_bvalid_i) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit    = (state_q == RESP) && !m_bvalid_i && (tmo_q == TW'(TMO - 1));
  // A B that shows up after the timeout is swallowed while idle.
  assign m_bready_o = (state_q == RESP) || (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit    = 1'b0;
  assign m_bready_o = (state_q == RESP);
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d  = ADDR;
        last_d   = pick;
        gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick;
        awaddr_d = req_addr_i[pick*AW +: AW];
        awlen_d  = req_len_i[pick*4 +: 4];
      end
      ADDR: if (m_awready_i) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (w_hs) begin
        cnt_d = cnt_q + 4'd1;
        if (m_wlast_o) state_d = RESP;
      end
      RESP: if (m_bvalid_i || tmo_hit) begin
        done_d  = gnt_q;
        if (!m_bvalid_i || m_bresp_i[1]) err_d = gnt_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= IW'(NREQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
